// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl -- instruction-fetch sequencer for the IF/ID stage.
//
// Issues one outstanding req/ack fetch at a time, tracks the fetch PC, and
// produces the IF/ID instruction-register load (ir_write/ir_data/ir_pc). A
// one-entry hold buffer absorbs an instruction that returns while the hazard
// unit stalls. A branch flush discards in-flight or buffered work and
// redirects fetch to branch_target.
//
// Optional feature: define IF_FLUSH_NOP_EN to load NOP_WORD (with
// ir_pc=branch_target) into IF/ID on every flush cycle. Without it, flush
// suppresses ir_write.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall             IF/ID register must not load this cycle
//   flush             branch/jump taken, discard in-flight instruction
//   branch_target     redirect address, valid with flush
//   imem_req/addr     fetch request and address to instruction memory
//   imem_ack/rdata    memory completion and returned instruction
//   ir_write/data/pc  combinational IF/ID load enable, instruction, its PC
//   ir_valid          registered, IF/ID holds a real instruction
module if_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_write,
  output logic [31:0] ir_data,
  output logic [31:0] ir_pc,
  output logic        ir_valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] hold_instr, hold_instr_nx;
  logic [31:0] hold_pc, hold_pc_nx;
  logic [31:0] redirect_pc, redirect_pc_nx;
  logic        ir_valid_nx;
  logic        fetched;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= PC_RESET;
      hold_instr  <= '0;
      hold_pc     <= '0;
      redirect_pc <= '0;
      ir_valid    <= 1'b0;
    end else begin
      state       <= state_nx;
      fetch_pc    <= fetch_pc_nx;
      hold_instr  <= hold_instr_nx;
      hold_pc     <= hold_pc_nx;
      redirect_pc <= redirect_pc_nx;
      ir_valid    <= ir_valid_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    fetch_pc_nx    = fetch_pc;
    hold_instr_nx  = hold_instr;
    hold_pc_nx     = hold_pc;
    redirect_pc_nx = redirect_pc;
    imem_req       = 1'b0;
    imem_addr      = fetch_pc;
    ir_write       = 1'b0;
    ir_data        = '0;
    ir_pc          = '0;
    fetched        = 1'b0;

    case (state)
      IDLE: state_nx = REQ;

      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (flush) begin
            fetch_pc_nx = branch_target;
          end else if (stall) begin
            hold_instr_nx = imem_rdata;
            hold_pc_nx    = fetch_pc;
            fetch_pc_nx   = fetch_pc + PC_STEP;
            state_nx      = HOLD;
          end else begin
            fetched     = 1'b1;
            ir_write    = 1'b1;
            ir_data     = imem_rdata;
            ir_pc       = fetch_pc;
            fetch_pc_nx = fetch_pc + PC_STEP;
          end
        end else if (flush) begin
          // Request already on the bus: let it finish, then redirect.
          redirect_pc_nx = branch_target;
          state_nx       = DRAIN;
        end
      end

      HOLD: begin
        if (flush) begin
          fetch_pc_nx = branch_target;
          state_nx    = REQ;
        end else if (!stall) begin
          fetched  = 1'b1;
          ir_write = 1'b1;
          ir_data  = hold_instr;
          ir_pc    = hold_pc;
          state_nx = REQ;
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (flush) redirect_pc_nx = branch_target;
        if (imem_ack) begin
          fetch_pc_nx = flush ? branch_target : redirect_pc;
          state_nx    = REQ;
        end
      end

      default: state_nx = IDLE;
    endcase

`ifdef IF_FLUSH_NOP_EN
    if (flush) begin
      ir_write = 1'b1;
      ir_data  = NOP_WORD;
      ir_pc    = branch_target;
    end
`endif

    // fetched is never set in a flush cycle, so flush always clears.
    if (flush)        ir_valid_nx = 1'b0;
    else if (fetched) ir_valid_nx = 1'b1;
    else              ir_valid_nx = ir_valid;
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table from reset, an asynchronous
// reset-mid-transfer sequence, and a random phase checked against a
// transaction-level reference model.
module tb_if_fetch_ctrl;

`ifdef IF_FLUSH_NOP_EN
  localparam bit NOP_MODE = 1'b1;
`else
  localparam bit NOP_MODE = 1'b0;
`endif
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_target = '0, imem_rdata = '0;
  logic        imem_req, ir_write, ir_valid;
  logic [31:0] imem_addr, ir_data, ir_pc;

  int checks = 0;
  int errors = 0;

  if_fetch_ctrl #(.PC_RESET(32'h0), .PC_STEP(32'd4), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_write(ir_write),
    .ir_data(ir_data), .ir_pc(ir_pc), .ir_valid(ir_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int idx,
                          input logic req, input logic [31:0] addr,
                          input logic wr, input logic [31:0] data,
                          input logic [31:0] pc, input logic valid);
    chk({tag, ".req"},   idx, {31'b0, imem_req}, {31'b0, req});
    chk({tag, ".addr"},  idx, imem_addr, addr);
    chk({tag, ".write"}, idx, {31'b0, ir_write}, {31'b0, wr});
    chk({tag, ".data"},  idx, ir_data, data);
    chk({tag, ".pc"},    idx, ir_pc, pc);
    chk({tag, ".valid"}, idx, {31'b0, ir_valid}, {31'b0, valid});
  endtask

  typedef struct {
    logic        stall, flush, ack;
    logic [31:0] target, rdata;
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data, pc;
    logic        valid;
  } vec_t;

  localparam int NV = 23;
  vec_t vt[NV];

  function automatic vec_t mk(logic s, logic f, logic a, logic [31:0] t,
                              logic [31:0] rd, logic rq, logic [31:0] ad,
                              logic w, logic [31:0] d, logic [31:0] p, logic v);
    vec_t r;
    r.stall = s; r.flush = f; r.ack = a; r.target = t; r.rdata = rd;
    r.req = rq; r.addr = ad; r.wr = w; r.data = d; r.pc = p; r.valid = v;
    return r;
  endfunction

  function automatic logic [31:0] wd(int n);
    return 32'hC0DE_0000 + n;
  endfunction

  // Reference model: fetch progress as "next address", an optional doomed
  // in-flight request with its pending redirect, and a queue of buffered
  // instructions (at most one).
  typedef struct { logic [31:0] instr, pc; } held_t;
  bit          m_started, m_doomed, m_valid;
  logic [31:0] m_pc, m_redir;
  held_t       m_held[$];

  task automatic model_reset();
    m_started = 0; m_doomed = 0; m_valid = 0;
    m_pc = 32'h0; m_redir = 32'h0;
    m_held.delete();
  endtask

  initial begin
    logic        e_req, e_wr;
    logic [31:0] e_data, e_pc;
    held_t       h;

    // Reset state
    #2;
    chk_outs("rst", 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vector table
    vt[0]  = mk(0,0,1,0,JUNK,      0,32'h00,0,0,0,0);
    vt[1]  = mk(0,0,1,0,wd(0),     1,32'h00,1,wd(0),32'h00,0);
    vt[2]  = mk(0,0,1,0,wd(1),     1,32'h04,1,wd(1),32'h04,1);
    vt[3]  = mk(0,0,1,0,wd(2),     1,32'h08,1,wd(2),32'h08,1);
    vt[4]  = mk(0,0,1,0,wd(3),     1,32'h0C,1,wd(3),32'h0C,1);
    vt[5]  = mk(0,0,0,0,JUNK,      1,32'h10,0,0,0,1);
    vt[6]  = mk(0,0,0,0,JUNK,      1,32'h10,0,0,0,1);
    vt[7]  = mk(0,0,0,0,JUNK,      1,32'h10,0,0,0,1);
    vt[8]  = mk(0,0,1,0,wd(4),     1,32'h10,1,wd(4),32'h10,1);
    vt[9]  = mk(0,0,1,0,wd(5),     1,32'h14,1,wd(5),32'h14,1);
    vt[10] = mk(0,0,1,0,wd(6),     1,32'h18,1,wd(6),32'h18,1);
    vt[11] = mk(0,0,1,0,wd(7),     1,32'h1C,1,wd(7),32'h1C,1);
    vt[12] = mk(1,0,1,0,wd(8),     1,32'h20,0,0,0,1);
    vt[13] = mk(1,0,1,0,JUNK,      0,32'h24,0,0,0,1);
    vt[14] = mk(0,0,0,0,JUNK,      0,32'h24,1,wd(8),32'h20,1);
    vt[15] = mk(0,1,0,32'h100,JUNK,1,32'h24,0,0,0,1);
    vt[16] = mk(0,0,0,0,JUNK,      1,32'h24,0,0,0,0);
    vt[17] = mk(0,0,1,0,JUNK,      1,32'h24,0,0,0,0);
    vt[18] = mk(0,0,1,0,wd(9),     1,32'h100,1,wd(9),32'h100,0);
    vt[19] = mk(1,0,1,0,wd(10),    1,32'h104,0,0,0,1);
    vt[20] = mk(1,1,0,32'h200,JUNK,0,32'h108,0,0,0,1);
    vt[21] = mk(0,0,0,0,JUNK,      1,32'h200,0,0,0,0);
    vt[22] = mk(0,0,1,0,wd(11),    1,32'h200,1,wd(11),32'h200,0);
    for (int i = 0; i < NV; i++)
      if (NOP_MODE && vt[i].flush) begin
        vt[i].wr = 1'b1; vt[i].data = NOP; vt[i].pc = vt[i].target;
      end

    for (int i = 0; i < NV; i++) begin
      stall = vt[i].stall; flush = vt[i].flush; imem_ack = vt[i].ack;
      branch_target = vt[i].target; imem_rdata = vt[i].rdata;
      @(negedge clk);
      chk_outs("vec", i, vt[i].req, vt[i].addr, vt[i].wr, vt[i].data,
               vt[i].pc, vt[i].valid);
      @(posedge clk); #1;
    end

    // Reset pulsed while a request at 0x40 is pending
    stall = 0; flush = 1; imem_ack = 1; branch_target = 32'h40; imem_rdata = JUNK;
    @(posedge clk); #1;
    flush = 0; imem_ack = 0; branch_target = 0;
    #2;
    chk("arst.pre_req", 0, {31'b0, imem_req}, 32'h1);
    chk("arst.pre_addr", 0, imem_addr, 32'h40);
    rst_n = 1'b0;
    #1;
    chk("arst.req", 0, {31'b0, imem_req}, 32'h0);
    chk("arst.addr", 0, imem_addr, 32'h0);
    chk("arst.valid", 0, {31'b0, ir_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ack = 1; imem_rdata = wd(20);
    @(negedge clk);
    chk_outs("arst.idle", 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_outs("arst.restart", 0, 1'b1, 32'h0, 1'b1, wd(20), 32'h0, 1'b0);
    @(posedge clk); #1;

    // Random phase against the reference model
    rst_n = 1'b0; imem_ack = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom % 4) == 0;
      flush = ($urandom % 8) == 0;
      imem_ack = ($urandom % 3) != 0;
      branch_target = (($urandom % 4) == 0) ? 32'hFFFF_FFFC
                                            : ($urandom & 32'hFFFF_FFFC);
      imem_rdata = $urandom;

      e_req = m_started && (m_held.size() == 0);
      e_wr = 0; e_data = 0; e_pc = 0;
      if (flush) begin
        if (NOP_MODE) begin e_wr = 1; e_data = NOP; e_pc = branch_target; end
      end else if (m_held.size() != 0) begin
        if (!stall) begin e_wr = 1; e_data = m_held[0].instr; e_pc = m_held[0].pc; end
      end else if (e_req && imem_ack && !m_doomed && !stall) begin
        e_wr = 1; e_data = imem_rdata; e_pc = m_pc;
      end

      @(negedge clk);
      chk_outs("rnd", c, e_req, m_pc, e_wr, e_data, e_pc, m_valid);
      @(posedge clk); #1;

      if (!m_started) begin
        m_started = 1;
      end else if (m_held.size() != 0) begin
        if (flush) begin
          m_held.delete(); m_pc = branch_target;
        end else if (!stall) begin
          h = m_held.pop_front(); m_valid = 1;
        end
      end else if (m_doomed) begin
        if (flush) m_redir = branch_target;
        if (imem_ack) begin m_doomed = 0; m_pc = m_redir; end
      end else if (imem_ack) begin
        if (flush) m_pc = branch_target;
        else if (stall) begin
          h.instr = imem_rdata; h.pc = m_pc;
          m_held.push_back(h); m_pc = m_pc + 32'd4;
        end else begin
          m_pc = m_pc + 32'd4; m_valid = 1;
        end
      end else if (flush) begin
        m_doomed = 1; m_redir = branch_target;
      end
      if (flush) m_valid = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
